// File: rtl/psum_deskew_collector.sv
`default_nettype none
// ============================================================================
//  Module      : psum_deskew_collector
//  Description : Receives the skewed south-side psum lanes of a mac_row. Lane i
//                arrives one cycle after lane i-1, so each lane is delayed by
//                (col-1-i) stages until all lanes line up. Every fully valid
//                aligned row is pushed into a first-word-fall-through FIFO that
//                the consumer drains through a valid/ready handshake.
//  Ports       : clk        rising-edge clock
//                reset      synchronous, active-low (0 = reset)
//                in_psum    col lanes of psum_bw bits, lane i at [bw*i +: bw]
//                in_valid   per-lane valid, bit i qualifies lane i
//                out_data   head FIFO row (0 while the FIFO is empty)
//                out_valid  FIFO not empty
//                out_ready  consumer accepts the head row when valid && ready
//                full       FIFO holds depth rows
//                count      rows currently in the FIFO
//                overflow   sticky: a complete aligned row was dropped
//                align_err  sticky: an aligned valid vector was partial
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_deskew_collector #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [psum_bw*col-1:0]     in_psum,
    input  logic [col-1:0]             in_valid,
    output logic [psum_bw*col-1:0]     out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       full,
    output logic [$clog2(depth):0]     count,
    output logic                       overflow,
    output logic                       align_err
);

    localparam int               c_aw       = $clog2(depth);
    localparam int               c_w        = psum_bw * col;
    localparam logic [c_aw:0]    c_full_cnt = (c_aw + 1)'(depth);

    logic [col-1:0]  aligned_v;
    logic [c_w-1:0]  aligned_d;

    // ------------------------------------------------------------------
    // Deskew: lane i passes through (col-1-i) stages; the last lane is
    // used directly. Only the valid bits are reset, data is don't-care.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < col; gi++) begin : g_lane
        localparam int c_stages = col - 1 - gi;
        if (c_stages == 0) begin : g_direct
            assign aligned_v[gi]                    = in_valid[gi];
            assign aligned_d[psum_bw*gi +: psum_bw] = in_psum[psum_bw*gi +: psum_bw];
        end else begin : g_delay
            logic [c_stages-1:0] v_q;
            logic [c_stages-1:0] v_d;
            logic [psum_bw-1:0]  d_q [0:c_stages-1];
            logic [psum_bw-1:0]  d_d [0:c_stages-1];

            always_comb begin
                v_d[0] = in_valid[gi];
                d_d[0] = in_psum[psum_bw*gi +: psum_bw];
                for (int s = 1; s < c_stages; s++) begin
                    v_d[s] = v_q[s-1];
                    d_d[s] = d_q[s-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    v_q <= '0;
                end else begin
                    v_q <= v_d;
                end
                d_q <= d_d;
            end

            assign aligned_v[gi]                    = v_q[c_stages-1];
            assign aligned_d[psum_bw*gi +: psum_bw] = d_q[c_stages-1];
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_aw:0]   count_q,  count_d;
    logic            overflow_q,  overflow_d;
    logic            align_err_q, align_err_d;
    logic [c_w-1:0]  mem_q [0:depth-1];

    logic row_all;
    logic row_none;
    logic fifo_full;
    logic fifo_nempty;
    logic pop;
    logic push;

    always_comb begin
        row_all     = &aligned_v;
        row_none    = ~|aligned_v;
        fifo_full   = (count_q == c_full_cnt);
        fifo_nempty = (count_q != '0);
        pop         = fifo_nempty && out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push        = row_all && (!fifo_full || pop);

        wr_ptr_d    = push ? wr_ptr_q + c_aw'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + c_aw'(1) : rd_ptr_q;
        count_d     = count_q + {{c_aw{1'b0}}, push} - {{c_aw{1'b0}}, pop};
        overflow_d  = overflow_q  | (row_all && fifo_full && !pop);
        align_err_d = align_err_q | (!row_all && !row_none);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            align_err_q <= align_err_d;
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= aligned_d;
        end
    end

    // Fall-through head; forced to zero while empty so stale entries never show.
    assign out_data  = fifo_nempty ? mem_q[rd_ptr_q] : '0;
    assign out_valid = fifo_nempty;
    assign full      = fifo_full;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign align_err = align_err_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_deskew_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_deskew_collector
//  Description : Self-checking bench for psum_deskew_collector. Rows are
//                scheduled by launch cycle (lane i appears launch+i); a
//                behavioural model tracks which lanes survive resets, which
//                rows complete, and the FIFO contents as a queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_deskew_collector;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 8;
    localparam int W     = COL * BW;
    localparam int MAXC  = 4096;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   in_psum = '0;
    logic [COL-1:0] in_valid = '0;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           full;
    logic [3:0]     count;
    logic           overflow;
    logic           align_err;

    always #5 clk = ~clk;

    psum_deskew_collector #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_psum   (in_psum),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .align_err (align_err)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [W-1:0]   sched_d  [MAXC];
    logic [COL-1:0] sched_m  [MAXC];
    bit             sched_on [MAXC];
    bit             rst_edge [MAXC];

    logic [W-1:0] q[$];
    bit m_ovf = 1'b0;
    bit m_aerr = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic sched_row(input int l, input logic [W-1:0] d, input logic [COL-1:0] m);
        sched_on[l] = 1'b1;
        sched_d[l]  = d;
        sched_m[l]  = m;
    endtask

    // Present, for the current cycle, lane i of the row launched at cyc-i.
    task automatic drive();
        for (int i = 0; i < COL; i++) begin
            int l;
            l = cyc - i;
            if (l >= 0 && sched_on[l] && sched_m[l][i]) begin
                in_valid[i]         = 1'b1;
                in_psum[BW*i +: BW] = sched_d[l][BW*i +: BW];
            end else begin
                in_valid[i]         = 1'b0;
                in_psum[BW*i +: BW] = BW'($urandom);
            end
        end
    endtask

    task automatic check_outputs();
        check("count",     W'(count),     W'(q.size()));
        check("out_valid", W'(out_valid), W'(q.size() != 0));
        check("full",      W'(full),      W'(q.size() == DEPTH));
        check("overflow",  W'(overflow),  W'(m_ovf));
        check("align_err", W'(align_err), W'(m_aerr));
        check("out_data",  out_data,      (q.size() != 0) ? q[0] : '0);
    endtask

    // Reference behaviour for the clock edge that ends the current cycle.
    task automatic model_edge(input bit rdy, input bit rst_n);
        logic [COL-1:0] av;
        bit pop;
        bit full_now;
        int l;
        if (!rst_n) begin
            q.delete();
            m_ovf  = 1'b0;
            m_aerr = 1'b0;
            rst_edge[cyc] = 1'b1;
            return;
        end
        av = '0;
        l  = cyc - (COL - 1);
        if (l >= 0 && sched_on[l]) begin
            for (int i = 0; i < COL; i++) begin
                if (sched_m[l][i]) begin
                    bit alive;
                    alive = 1'b1;
                    // A lane captured on or after a reset edge was wiped.
                    for (int e = l + i; e < cyc; e++) if (rst_edge[e]) alive = 1'b0;
                    av[i] = alive;
                end
            end
        end
        full_now = (q.size() == DEPTH);
        pop      = rdy && (q.size() != 0);
        if (pop) void'(q.pop_front());
        if (&av) begin
            if (full_now && !pop) m_ovf = 1'b1;
            else                  q.push_back(sched_d[l]);
        end else if (av != '0) begin
            m_aerr = 1'b1;
        end
    endtask

    task automatic tick(input bit rdy, input bit rst_n);
        reset     = rst_n;
        out_ready = rdy;
        drive();
        check_outputs();
        model_edge(rdy, rst_n);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        logic [W-1:0] t1;
        int l;
        int maxc;

        @(negedge clk);
        repeat (3) tick(1'b0, 1'b0);

        // Single row launched in cycle 3; lane i = 0x0100+i.
        for (int i = 0; i < COL; i++) t1[BW*i +: BW] = BW'(16'h0100 + i);
        sched_row(cyc, t1, '1);
        repeat (7) tick(1'b0, 1'b1);
        check("t1_not_early", W'(out_valid), W'(0));
        tick(1'b0, 1'b1);
        check("t1_cycle", W'(cyc), W'(11));
        check("t1_valid", W'(out_valid), W'(1));
        check("t1_data", out_data, t1);
        check("t1_count", W'(count), W'(1));
        repeat (3) tick(1'b1, 1'b1);

        // Four back-to-back rows with the consumer always ready.
        for (int k = 0; k < 4; k++) sched_row(cyc + k, rand_row(), '1);
        maxc = 0;
        for (int k = 0; k < 14; k++) begin
            if (int'(count) > maxc) maxc = int'(count);
            tick(1'b1, 1'b1);
        end
        check("t2_maxcount", W'(maxc), W'(1));

        // Nine rows with no consumer: ninth is dropped, then drain.
        for (int k = 0; k < 9; k++) sched_row(cyc + k, rand_row(), '1);
        repeat (17) tick(1'b0, 1'b1);
        check("t3_full", W'(full), W'(1));
        check("t3_overflow", W'(overflow), W'(1));
        repeat (10) tick(1'b1, 1'b1);

        // Full FIFO with push and pop in the same cycle.
        repeat (2) tick(1'b0, 1'b0);
        l = cyc;
        for (int k = 0; k < 9; k++) sched_row(l + k, rand_row(), '1);
        while (cyc < l + 15) tick(1'b0, 1'b1);
        check("t4_full_before", W'(count), W'(8));
        tick(1'b1, 1'b1);
        check("t4_count_kept", W'(count), W'(8));
        check("t4_no_overflow", W'(overflow), W'(0));
        repeat (3) tick(1'b0, 1'b1);
        repeat (10) tick(1'b1, 1'b1);

        // Lane 3 missing from one row, well-formed row right behind it.
        repeat (2) tick(1'b0, 1'b0);
        sched_row(cyc, rand_row(), 8'hF7);
        sched_row(cyc + 1, rand_row(), '1);
        repeat (10) tick(1'b0, 1'b1);
        check("t5_align_err", W'(align_err), W'(1));
        check("t5_one_row", W'(count), W'(1));
        repeat (3) tick(1'b1, 1'b1);

        // Randomised traffic with occasional partial rows and random backpressure.
        repeat (2) tick(1'b0, 1'b0);
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(2) != 0) begin
                if ($urandom_range(9) == 0) sched_row(cyc, rand_row(), COL'($urandom));
                else                        sched_row(cyc, rand_row(), '1);
            end
            tick(1'($urandom_range(1)), 1'b1);
        end
        repeat (20) tick(1'b1, 1'b1);

        // Reset mid-row with two rows queued.
        repeat (2) tick(1'b0, 1'b0);
        sched_row(cyc, rand_row(), '1);
        sched_row(cyc + 1, rand_row(), '1);
        repeat (10) tick(1'b0, 1'b1);
        check("t6_queued", W'(count), W'(2));
        l = cyc;
        sched_row(l, rand_row(), '1);
        repeat (4) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("t6_count_cleared", W'(count), W'(0));
        check("t6_valid_cleared", W'(out_valid), W'(0));
        repeat (3) tick(1'b0, 1'b0);
        repeat (15) tick(1'b1, 1'b1);
        check("t6_no_row", W'(out_valid), W'(0));
        check("t6_no_err", W'(align_err), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
